sw_perf_monitor: RTL
====================

// Module: sw_perf_monitor
// PURPOSE
//  Board-level performance monitor for the Smith-Waterman accelerator.
//  - Captures each alignment result.
//  - Measures start-to-valid latency and busy duration in CLOCK cycles.
//  - Counts completed runs.
//  - Drives one registered, selectable display word to the LEDs.
//  - Sits between FPGAWrapper outputs and the DE2-115 LED/HEX logic; replaces ad-hoc timers.
// PARAMETERS
//  DATA_W  18  width of the captured result (FPGAWrapper o_result)
//  TIME_W  26  width of each saturating cycle timer
//  RUN_W    8  width of the completed-run counter
//  DISP_W  26  display word width; must be >= max(DATA_W, TIME_W, RUN_W)
// PORTS
//  CLOCK       in   1       system clock
//  RST_N       in   1       reset RST_N, asynchronous, active-low
//  i_start     in   1       start-calculation pulse (debounced key)
//  i_busy      in   1       accelerator busy level
//  i_valid     in   1       result-valid pulse, 1 cycle
//  i_data      in   DATA_W  result, sampled when i_valid=1
//  i_clear     in   1       synchronous clear of all statistics
//  i_sel       in   2       display select: 00 result, 01 runs/max, 10 latency, 11 busy
//  o_disp      out  DISP_W  selected word, zero-extended, registered
//  o_state     out  2       FSM state encoding: IDLE=0, WAIT=1, DONE=2
//  o_overflow  out  1       sticky flag: any timer or counter saturated
// BEHAVIOUR
//  Reset: all timers, o_disp, run count and o_overflow = 0; captured result = 0; FSM = IDLE.
//  Reset mid-run aborts the run; no partial capture survives reset.
//  FSM:
//  - IDLE --i_start--> WAIT
//  - WAIT --i_valid--> DONE
//  - DONE --i_start--> WAIT
//  - i_valid outside WAIT is ignored: no capture, no run count.
//  Latency timer:
//  - Loads 0 on the i_start cycle.
//  - Increments by 1 every cycle spent in WAIT.
//  - Frozen in IDLE and DONE.
//  - Value at capture = cycles from start edge to valid edge, exclusive of the start cycle.
//  Busy timer:
//  - Loads 1 on the i_busy rising edge (busy=1, previous busy=0).
//  - Increments while i_busy=1; holds after i_busy falls.
//  - Independent of the FSM.
//  Capture: on i_valid in WAIT, the result register <= i_data and the run count increments, in the same cycle.
//  Simultaneous i_start and i_valid in WAIT: i_start wins; latency restarts, valid is dropped, FSM stays in WAIT.
//  Saturation:
//  - Timers and the run count stick at all-ones; they never wrap.
//  - Reaching all-ones sets o_overflow.
//  - o_overflow clears only on reset or i_clear.
//  i_clear:
//  - Zeroes both timers, the run count, the result register and o_overflow; FSM -> IDLE.
//  - Priority over i_start and i_valid in the same cycle.
//  o_disp latency: registered; o_disp reflects i_sel and the internal state 1 cycle later.
// CONFIGURATION
//  Macro SW_PERF_MAX_LAT_EN:
//  - Defined: add a TIME_W max-latency register, updated on each capture with max(old, latency).
//    i_sel=01 shows max latency; i_clear zeroes it.
//  - Undefined: no max register; i_sel=01 shows the run count.
// STRUCTURE
//  Package sw_perf_pkg:
//  - typedef enum logic[1:0] perf_state_t {IDLE, WAIT, DONE}.
//  - localparams SEL_RESULT=2'b00, SEL_RUNS=2'b01, SEL_LAT=2'b10, SEL_BUSY=2'b11.
//  Sub-module sat_counter #(W):
//  - Ports: clk, rst_n, clr, load1, inc, o_cnt, o_sat.
//  - Instantiated 3 times: latency, busy, runs.
// TESTING
//  1. Start at t0, valid at t0+5 with data=18'h0ABCD -> state DONE, latency=5, runs=1, sel=00 shows 0x0ABCD next cycle.
//  2. Valid with no preceding start -> result, runs and latency unchanged; state IDLE.
//  3. Busy high 100 cycles, low, then high 3 cycles -> sel=11 shows 100, then 3.
//  4. TIME_W=4, start then 20 cycles without valid -> latency held at 15, o_overflow=1; i_clear -> 0, state IDLE.
//  5. Start and valid in the same cycle while in WAIT -> latency=0, runs unchanged, state WAIT.
//  6. With SW_PERF_MAX_LAT_EN, runs of latency 7, 3, 9 -> sel=01 shows 9; without the macro -> sel=01 shows 3.

Source files
------------

// File: rtl/sw_perf_pkg.sv
// sw_perf_pkg: shared FSM state and display-select encodings for sw_perf_monitor.
package sw_perf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} perf_state_t;
  localparam logic [1:0] SEL_RESULT = 2'b00;
  localparam logic [1:0] SEL_RUNS = 2'b01;
  localparam logic [1:0] SEL_LAT = 2'b10;
  localparam logic [1:0] SEL_BUSY = 2'b11;
endpackage

// File: rtl/sw_perf_monitor_sat_counter.sv
// sat_counter: saturating up-counter with clear, load-to-one and sticky-at-all-ones behaviour.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);
  assign o_sat = &o_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_cnt <= '0;
    else if (clr) o_cnt <= '0;
    else if (load1) o_cnt <= W'(1);
    else if (inc && !o_sat) o_cnt <= o_cnt + W'(1);
endmodule

// File: rtl/sw_perf_monitor.sv
// sw_perf_monitor: result capture, latency/busy timers and run counter for the SW accelerator.
// Define SW_PERF_MAX_LAT_EN to add a max-latency register shown on select 01.
module sw_perf_monitor
  import sw_perf_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int TIME_W = 26,
  parameter int RUN_W  = 8,
  parameter int DISP_W = 26
) (
  input  logic              CLOCK,
  input  logic              RST_N,
  input  logic              i_start,
  input  logic              i_busy,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  input  logic [1:0]        i_sel,
  output logic [DISP_W-1:0] o_disp,
  output logic [1:0]        o_state,
  output logic              o_overflow
);
  perf_state_t state_q, state_d;
  logic start, capture, busy_q;
  logic lat_sat, busy_sat, run_sat;
  logic [TIME_W-1:0] lat_cnt, busy_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [DATA_W-1:0] result_q;
  logic [DISP_W-1:0] runs_word, disp_d;
  // start beats a same-cycle valid; clear beats both
  assign start = i_start && !i_clear;
  assign capture = state_q == WAIT && i_valid && !i_start && !i_clear;
  always_comb begin
    state_d = state_q;
    if (i_clear) state_d = IDLE;
    else if (i_start) state_d = WAIT;
    else if (capture) state_d = DONE;
  end
  always_ff @(posedge CLOCK or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  sat_counter #(.W(TIME_W)) u_lat (
    .clk(CLOCK), .rst_n(RST_N), .clr(i_clear || start), .load1(1'b0),
    .inc(state_q == WAIT), .o_cnt(lat_cnt), .o_sat(lat_sat)
  );
  sat_counter #(.W(TIME_W)) u_busy (
    .clk(CLOCK), .rst_n(RST_N), .clr(i_clear), .load1(i_busy && !busy_q),
    .inc(i_busy), .o_cnt(busy_cnt), .o_sat(busy_sat)
  );
  sat_counter #(.W(RUN_W)) u_runs (
    .clk(CLOCK), .rst_n(RST_N), .clr(i_clear), .load1(1'b0),
    .inc(capture), .o_cnt(run_cnt), .o_sat(run_sat)
  );
  always_ff @(posedge CLOCK or negedge RST_N)
    if (!RST_N) begin
      busy_q <= 1'b0;
      result_q <= '0;
      o_overflow <= 1'b0;
    end else begin
      busy_q <= i_busy;
      result_q <= i_clear ? '0 : capture ? i_data : result_q;
      o_overflow <= !i_clear && (o_overflow || lat_sat || busy_sat || run_sat);
    end
`ifdef SW_PERF_MAX_LAT_EN
  logic [TIME_W-1:0] max_q, cap_lat;
  // the latency counter also steps on the capture cycle, so compare against its next value
  assign cap_lat = lat_sat ? lat_cnt : lat_cnt + TIME_W'(1);
  always_ff @(posedge CLOCK or negedge RST_N)
    if (!RST_N) max_q <= '0;
    else if (i_clear) max_q <= '0;
    else if (capture && cap_lat > max_q) max_q <= cap_lat;
  assign runs_word = DISP_W'(max_q);
`else
  assign runs_word = DISP_W'(run_cnt);
`endif
  always_comb
    disp_d = i_sel == SEL_RESULT ? DISP_W'(result_q) :
             i_sel == SEL_RUNS   ? runs_word :
             i_sel == SEL_LAT    ? DISP_W'(lat_cnt) : DISP_W'(busy_cnt);
  always_ff @(posedge CLOCK or negedge RST_N)
    if (!RST_N) o_disp <= '0;
    else o_disp <= disp_d;
  assign o_state = state_q;
endmodule
